my_mem_parity_store: RTL and testbench



---
 rtl/my_mem_parity_store.sv | 84 ++++++++
 tb/tb_my_mem_parity_store.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/my_mem_parity_store.sv
// my_mem_parity_store: even-parity 9-bit word store with uninit/collision/parity tracking.
module my_mem_parity_store #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            data_in,
  input  logic                  err_inject,
  output logic [8:0]            data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  uninit_rd,
  output logic [CNT_WIDTH-1:0]  collision_count,
  output logic [CNT_WIDTH-1:0]  parity_err_count
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [8:0]            mem [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_uninit_q, rd_uninit_d;
  logic [8:0]            rd_word_q, rd_word_d;
  logic [8:0]            data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  uninit_rd_q, uninit_rd_d;
  logic [CNT_WIDTH-1:0]  coll_cnt_q, coll_cnt_d;
  logic [CNT_WIDTH-1:0]  perr_cnt_q, perr_cnt_d;
  logic                  wr, rd, coll;
  always_comb begin
    wr = write & ~read;
    rd = read & ~write;
    coll = write & read;
    valid_d = valid_q;
    if (wr) valid_d[address] = 1'b1;
    rd_pend_d = rd;
    rd_uninit_d = ~valid_q[address];
    rd_word_d = rd_uninit_d ? 9'h000 : mem[address];
    data_valid_d = rd_pend_q;
    data_out_d = rd_pend_q ? rd_word_q : data_out_q;
    parity_err_d = rd_pend_q & (^rd_word_q);
    uninit_rd_d = rd_pend_q & rd_uninit_q;
    coll_cnt_d = (coll && !(&coll_cnt_q)) ? coll_cnt_q + 1'b1 : coll_cnt_q;
    perr_cnt_d = (parity_err_d && !(&perr_cnt_q)) ? perr_cnt_q + 1'b1 : perr_cnt_q;
  end
  // Memory contents survive reset; only the bitmap marks them usable.
  always_ff @(posedge clk) begin
    if (!rst && wr) mem[address] <= {(^data_in) ^ err_inject, data_in};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      rd_pend_q    <= 1'b0;
      rd_uninit_q  <= 1'b0;
      rd_word_q    <= 9'h000;
      data_out_q   <= 9'h000;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      uninit_rd_q  <= 1'b0;
      coll_cnt_q   <= '0;
      perr_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      rd_pend_q    <= rd_pend_d;
      rd_uninit_q  <= rd_uninit_d;
      rd_word_q    <= rd_word_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      uninit_rd_q  <= uninit_rd_d;
      coll_cnt_q   <= coll_cnt_d;
      perr_cnt_q   <= perr_cnt_d;
    end
  end
  assign data_out         = data_out_q;
  assign data_valid       = data_valid_q;
  assign parity_err       = parity_err_q;
  assign uninit_rd        = uninit_rd_q;
  assign collision_count  = coll_cnt_q;
  assign parity_err_count = perr_cnt_q;
endmodule

// File: tb/tb_my_mem_parity_store.sv
// tb_my_mem_parity_store: directed table, reset/saturation sequences and random traffic vs a transaction model.
module tb_my_mem_parity_store;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, write, read, err_inject;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic [8:0]  data_out;
  logic        data_valid, parity_err, uninit_rd;
  logic [31:0] collision_count, parity_err_count;
  my_mem_parity_store dut (
    .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
    .data_in(data_in), .err_inject(err_inject), .data_out(data_out),
    .data_valid(data_valid), .parity_err(parity_err), .uninit_rd(uninit_rd),
    .collision_count(collision_count), .parity_err_count(parity_err_count)
  );
  logic       rst2, write2, read2;
  logic [8:0] data_out2;
  logic       data_valid2, parity_err2, uninit_rd2;
  logic [3:0] coll2, perr2;
  my_mem_parity_store #(.ADDR_WIDTH(4), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst2), .write(write2), .read(read2), .address(4'h3),
    .data_in(8'h5A), .err_inject(1'b0), .data_out(data_out2),
    .data_valid(data_valid2), .parity_err(parity_err2), .uninit_rd(uninit_rd2),
    .collision_count(coll2), .parity_err_count(perr2)
  );
  int total = 0, bad = 0;
  bit [8:0]  mmem [0:65535];
  bit        mvalid [0:65535];
  bit        pend, pend_un;
  bit [8:0]  pend_word;
  bit [8:0]  e_data;
  bit        e_valid, e_perr, e_un;
  bit [31:0] e_coll, e_perrc;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input bit w, input bit r, input bit [15:0] a, input bit [7:0] d, input bit e);
    write = w; read = r; address = a; data_in = d; err_inject = e;
    @(posedge clk); #1;
    if (rst) begin
      foreach (mvalid[i]) mvalid[i] = 1'b0;
      pend = 0; e_valid = 0; e_data = 0; e_perr = 0; e_un = 0; e_coll = 0; e_perrc = 0;
    end else begin
      e_valid = pend;
      e_perr = pend && (^pend_word);
      e_un = pend && pend_un;
      if (pend) e_data = pend_word;
      if (e_perr && e_perrc != 32'hFFFF_FFFF) e_perrc++;
      pend = r && !w;
      pend_un = !mvalid[a];
      pend_word = mvalid[a] ? mmem[a] : 9'h000;
      if (w && !r) begin
        mmem[a] = {(^d) ^ e, d};
        mvalid[a] = 1'b1;
      end
      if (w && r && e_coll != 32'hFFFF_FFFF) e_coll++;
    end
    check("data_valid", {31'b0, data_valid}, {31'b0, e_valid});
    check("data_out", {23'b0, data_out}, {23'b0, e_data});
    check("parity_err", {31'b0, parity_err}, {31'b0, e_perr});
    check("uninit_rd", {31'b0, uninit_rd}, {31'b0, e_un});
    check("collision_count", collision_count, e_coll);
    check("parity_err_count", parity_err_count, e_perrc);
  endtask
  typedef struct {
    bit w, r; bit [15:0] a; bit [7:0] d; bit e;
    bit v; bit [8:0] q; bit p, u;
  } vec_t;
  vec_t tbl [18];
  initial begin
    tbl[0]  = '{1, 0, 16'h0010, 8'hA5, 0, 0, 9'h000, 0, 0};
    tbl[1]  = '{0, 1, 16'h0010, 8'h00, 0, 0, 9'h000, 0, 0};
    tbl[2]  = '{0, 0, 16'h0000, 8'h00, 0, 1, 9'h0A5, 0, 0};
    tbl[3]  = '{1, 0, 16'h0020, 8'h07, 0, 0, 9'h0A5, 0, 0};
    tbl[4]  = '{0, 1, 16'h0020, 8'h00, 0, 0, 9'h0A5, 0, 0};
    tbl[5]  = '{0, 0, 16'h0000, 8'h00, 0, 1, 9'h107, 0, 0};
    tbl[6]  = '{1, 0, 16'h0020, 8'h07, 1, 0, 9'h107, 0, 0};
    tbl[7]  = '{0, 1, 16'h0020, 8'h00, 0, 0, 9'h107, 0, 0};
    tbl[8]  = '{0, 0, 16'h0000, 8'h00, 0, 1, 9'h007, 1, 0};
    tbl[9]  = '{0, 1, 16'hFFFF, 8'h00, 0, 0, 9'h007, 0, 0};
    tbl[10] = '{0, 0, 16'h0000, 8'h00, 0, 1, 9'h000, 0, 1};
    tbl[11] = '{1, 1, 16'h0010, 8'hFF, 0, 0, 9'h000, 0, 0};
    tbl[12] = '{1, 1, 16'h0010, 8'hFF, 0, 0, 9'h000, 0, 0};
    tbl[13] = '{1, 1, 16'h0010, 8'hFF, 0, 0, 9'h000, 0, 0};
    tbl[14] = '{0, 1, 16'h0010, 8'h00, 0, 0, 9'h000, 0, 0};
    tbl[15] = '{0, 1, 16'h0020, 8'h00, 0, 1, 9'h0A5, 0, 0};
    tbl[16] = '{0, 0, 16'h0000, 8'h00, 0, 1, 9'h007, 1, 0};
    tbl[17] = '{0, 0, 16'h0000, 8'h00, 0, 0, 9'h007, 0, 0};
    rst2 = 1; write2 = 0; read2 = 0;
    rst = 1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].e);
      check($sformatf("tbl%0d_valid", i), {31'b0, data_valid}, {31'b0, tbl[i].v});
      check($sformatf("tbl%0d_data", i), {23'b0, data_out}, {23'b0, tbl[i].q});
      check($sformatf("tbl%0d_perr", i), {31'b0, parity_err}, {31'b0, tbl[i].p});
      check($sformatf("tbl%0d_uninit", i), {31'b0, uninit_rd}, {31'b0, tbl[i].u});
      if (i == 8) check("perr_count_after_inject", parity_err_count, 32'd1);
      if (i == 13) check("coll_count_after_3", collision_count, 32'd3);
    end
    check("perr_count_after_b2b", parity_err_count, 32'd2);
    // A read followed immediately by reset must never produce its pulse.
    step(0, 1, 16'h0010, 0, 0);
    rst = 1;
    step(0, 0, 0, 0, 0);
    rst = 0;
    check("rst_drop_valid", {31'b0, data_valid}, 32'd0);
    check("rst_coll_zero", collision_count, 32'd0);
    check("rst_perr_zero", parity_err_count, 32'd0);
    step(0, 0, 0, 0, 0);
    check("rst_drop_valid_late", {31'b0, data_valid}, 32'd0);
    step(0, 1, 16'h0010, 0, 0);
    step(0, 0, 0, 0, 0);
    check("post_rst_uninit", {31'b0, uninit_rd}, 32'd1);
    check("post_rst_data", {23'b0, data_out}, 32'd0);
    // Reset beats a write sampled at the same edge.
    rst = 1;
    step(1, 0, 16'h0030, 8'h11, 0);
    rst = 0;
    step(0, 1, 16'h0030, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_write_discarded", {31'b0, uninit_rd}, 32'd1);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           ($urandom_range(0, 3) == 0) ? 16'(65528 + $urandom_range(0, 7)) : 16'($urandom_range(0, 7)),
           8'($urandom), $urandom_range(0, 5) == 0);
    end
    rst = 0;
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    rst2 = 0; write2 = 1; read2 = 1;
    for (int i = 0; i < 15; i++) @(negedge clk);
    check("sat_coll_15", {28'b0, coll2}, 32'hF);
    check("sat_no_valid", {31'b0, data_valid2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("sat_coll_hold", {28'b0, coll2}, 32'hF);
    write2 = 0; read2 = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
